alu_bitop_seq: RTL
==================

Name: alu_bitop_seq

Overview:
- Slice-serial bit-manipulation unit for the CPU ALU path: BIT (test), RES (clear), SET and TGL (toggle) on one selected bit of a WIDTH-bit operand.
- Processes the operand SLICE bits per clock, matching the nibble-serial ALU datapath.
- Generalises the fixed 8-bit BIT path to any width, adds write-back ops and a start/done handshake.
- Sits beside the main ALU, driven by the sequencer.

Parameters:
- WIDTH, 8: operand width in bits. Must be a multiple of SLICE.
- SLICE, 4: bits processed per cycle. NSLICE = WIDTH/SLICE.

Ports:
- clk  in  1  clock, rising edge
- nreset  in  1  asynchronous active-low reset
- start  in  1  request; sampled only when busy=0
- op  in  2  0=BIT, 1=RES, 2=SET, 3=TGL
- operand  in  WIDTH  source value, latched on accepted start
- bitsel  in  $clog2(WIDTH)  selected bit index, latched on accepted start
- carry_in  in  1  incoming carry flag, latched on accepted start
- busy  out  1  high while slices are being processed
- done  out  1  one-cycle completion pulse
- result  out  WIDTH  registered result
- zero  out  1  Z flag
- neg  out  1  N flag
- half  out  1  H flag
- carry  out  1  C flag

Behaviour:
- Reset (async, nreset=0):
  - state=IDLE.
  - busy, done, result, zero, neg, half, carry all 0.
  - Internal slice index and accumulator cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1: latch op, operand, bitsel and carry_in; index=0; go to RUN.
  - Otherwise stay in IDLE.
- RUN (busy=1):
  - Each edge processes slice[index] = operand[index*SLICE +: SLICE] with mask slice of (1 << bitsel).
  - Per-op slice result: BIT = s & m; RES = s & ~m; SET = s | m; TGL = s ^ m.
  - Writes the slice result into the accumulator.
  - ORs (s & m) into an internal hit bit.
  - After the slice at index NSLICE-1, go to DONE. Otherwise index increments.
  - start is ignored in RUN.
- DONE (done=1, busy=0):
  - result and flags are updated on the edge entering DONE. They hold those values until the next completion.
  - Flags for BIT: zero=!hit, neg=0, half=1, carry=latched carry_in.
  - Flags for RES/SET/TGL: flag registers keep their previous values; only result changes.
  - Next edge: go to RUN if start=1 (back-to-back accepted, new operands latched), else IDLE.
- Latency: done is high in the cycle after NSLICE+1 edges, counted from and including the edge that sampled start. For WIDTH=8/SLICE=4 that is 3 edges; throughput is one op per NSLICE+1 cycles.
- result and flags never show partial values during RUN.
- bitsel >= WIDTH (non-power-of-two WIDTH): mask is all zero. BIT then reports zero=1; RES/SET/TGL return operand unchanged.
- nreset asserted mid-RUN or in DONE: immediate return to reset values; no done pulse is produced for the aborted op.
- Width rules:
  - Mask is computed at WIDTH bits; no truncation of bitsel beyond its declared width.
  - Index counter width is $clog2(NSLICE), minimum 1.
  - NSLICE=1 is legal: RUN lasts one cycle.

Optional Feature:
- Macro ALU_BITOP_ABORT_EN.
- When defined:
  - Extra input port abort (1 bit).
  - abort=1 on an edge while in RUN returns to IDLE. done is not asserted; result and flags keep their previous values.
  - abort in IDLE or DONE has no effect. abort and start in the same DONE cycle: start wins.
- When undefined: no abort port; RUN always completes.

Decomposition:
- Package alu_bitop_pkg:
  - enum bitop_t {BOP_BIT, BOP_RES, BOP_SET, BOP_TGL}, 2 bits.
  - enum bitop_state_t {BST_IDLE, BST_RUN, BST_DONE}.
  - Function for the per-op slice operation.
- Sub-module alu_bitop_slice (combinational):
  - Inputs: SLICE-bit data, SLICE-bit mask, op.
  - Outputs: SLICE-bit result, hit (|(data & mask)).
  - Instantiated once and reused each RUN cycle.

Test Plan:
- WIDTH=8: BIT, operand=0x5A, bitsel=3, carry_in=0 -> done on 3rd edge; result=0x08, zero=0, neg=0, half=1, carry=0; busy high for exactly 2 cycles.
- BIT, operand=0x5A, bitsel=0, carry_in=1 -> result=0x00, zero=1, half=1, carry=1. Follow with SET 0x00 bit 7 -> result=0x80, zero still 1, carry still 1.
- RES 0xFF bit 4 -> 0xEF. TGL 0x0F bit 0 -> 0x0E. TGL 0x0E bit 0 -> 0x0F. Flags unchanged throughout.
- start pulsed every cycle -> done pulses exactly 3 cycles apart; start during RUN has no effect on latched operands (change operand mid-RUN, result unaffected).
- nreset low during RUN after a BIT start -> all outputs 0 immediately, no done; after release, an idle cycle keeps done=0.
- WIDTH=16, SLICE=4: BIT 0x8000 bit 15 -> done on 5th edge, result=0x8000, zero=0.
- With ALU_BITOP_ABORT_EN: abort in the 1st RUN cycle -> no done, result and flags unchanged from the previous op.

Source files
------------

// File: rtl/alu_bitop_pkg.sv
// alu_bitop_pkg: shared op/state encodings and the per-bit operation used by
// the slice-serial bit-manipulation unit.
package alu_bitop_pkg;

  typedef enum logic [1:0] {
    BOP_BIT = 2'd0,
    BOP_RES = 2'd1,
    BOP_SET = 2'd2,
    BOP_TGL = 2'd3
  } bitop_t;

  typedef enum logic [1:0] {
    BST_IDLE = 2'd0,
    BST_RUN  = 2'd1,
    BST_DONE = 2'd2
  } bitop_state_t;

  // One data bit against one mask bit; the slice applies this bitwise.
  function automatic logic bitop_apply(bitop_t op, logic s, logic m);
    logic r;
    case (op)
      BOP_BIT: r = s & m;
      BOP_RES: r = s & ~m;
      BOP_SET: r = s | m;
      default: r = s ^ m;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_bitop_slice.sv
// alu_bitop_slice: combinational BIT/RES/SET/TGL on one SLICE-bit chunk,
// plus the hit indication for the selected bit.
module alu_bitop_slice
  import alu_bitop_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] i_data,
  input  logic [SLICE-1:0] i_mask,
  input  bitop_t           i_op,
  output logic [SLICE-1:0] o_result,
  output logic             o_hit
);

  always_comb begin
    o_result = '0;
    for (int i = 0; i < SLICE; i++) begin
      o_result[i] = bitop_apply(i_op, i_data[i], i_mask[i]);
    end
  end

  assign o_hit = |(i_data & i_mask);

endmodule

// File: rtl/alu_bitop_seq.sv
// alu_bitop_seq: slice-serial single-bit test/clear/set/toggle with start/done
// handshake. Define ALU_BITOP_ABORT_EN to add an abort input that cancels RUN.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one slice per edge into the accumulator, busy=1
// DONE  | result/flags just updated, done=1 for one cycle
module alu_bitop_seq
  import alu_bitop_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SLICE = 4
) (
  input  logic                     clk,
  input  logic                     nreset,
`ifdef ALU_BITOP_ABORT_EN
  input  logic                     abort,
`endif
  input  logic                     start,
  input  logic [1:0]               op,
  input  logic [WIDTH-1:0]         operand,
  input  logic [$clog2(WIDTH)-1:0] bitsel,
  input  logic                     carry_in,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         result,
  output logic                     zero,
  output logic                     neg,
  output logic                     half,
  output logic                     carry
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int BSEL_W = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = BST_IDLE;
  localparam logic [1:0] S_RUN  = BST_RUN;
  localparam logic [1:0] S_DONE = BST_DONE;

  logic [1:0]        r_state;
  bitop_t            r_op;
  logic [WIDTH-1:0]  r_operand;
  logic [BSEL_W-1:0] r_bitsel;
  logic              r_cin;
  logic [IDX_W-1:0]  r_idx;
  logic [WIDTH-1:0]  r_acc;
  logic              r_hit;
  logic [WIDTH-1:0]  r_result;
  logic              r_zero;
  logic              r_neg;
  logic              r_half;
  logic              r_carry;

  logic [WIDTH-1:0]  w_mask;
  logic [WIDTH-1:0]  w_acc_next;
  logic [SLICE-1:0]  w_s_data;
  logic [SLICE-1:0]  w_s_mask;
  logic [SLICE-1:0]  w_s_res;
  logic              w_s_hit;
  logic              w_hit_next;
  logic              w_last;
  logic              w_accept;
  logic              w_abort;

`ifdef ALU_BITOP_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  // Shifting past the top bit yields an all-zero mask, which is what an
  // out-of-range bitsel must produce.
  assign w_mask = WIDTH'(1'b1) << r_bitsel;

  always_comb begin
    w_s_data = '0;
    w_s_mask = '0;
    for (int k = 0; k < NSLICE; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_s_data = r_operand[k*SLICE +: SLICE];
        w_s_mask = w_mask[k*SLICE +: SLICE];
      end
    end
  end

  alu_bitop_slice #(
    .SLICE (SLICE)
  ) u_slice (
    .i_data   (w_s_data),
    .i_mask   (w_s_mask),
    .i_op     (r_op),
    .o_result (w_s_res),
    .o_hit    (w_s_hit)
  );

  always_comb begin
    w_acc_next = r_acc;
    for (int k = 0; k < NSLICE; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_acc_next[k*SLICE +: SLICE] = w_s_res;
      end
    end
  end

  assign w_hit_next = r_hit | w_s_hit;
  assign w_last     = (r_idx == IDX_W'(NSLICE - 1));
  assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_op      <= BOP_BIT;
      r_operand <= '0;
      r_bitsel  <= '0;
      r_cin     <= 1'b0;
    end else if (w_accept) begin
      r_op      <= bitop_t'(op);
      r_operand <= operand;
      r_bitsel  <= bitsel;
      r_cin     <= carry_in;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_acc    <= '0;
      r_hit    <= 1'b0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_half   <= 1'b0;
      r_carry  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_idx   <= '0;
            r_hit   <= 1'b0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (w_abort) begin
            r_state <= S_IDLE;
          end else begin
            r_acc <= w_acc_next;
            r_hit <= w_hit_next;
            if (w_last) begin
              r_result <= w_acc_next;
              // Write-back ops leave the flag registers untouched.
              if (r_op == BOP_BIT) begin
                r_zero  <= ~w_hit_next;
                r_neg   <= 1'b0;
                r_half  <= 1'b1;
                r_carry <= r_cin;
              end
              r_state <= S_DONE;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = (r_state == S_RUN);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign zero   = r_zero;
  assign neg    = r_neg;
  assign half   = r_half;
  assign carry  = r_carry;

endmodule
